mmio_timer: RTL
===============

// Module: mmio_timer
// PURPOSE
// - Memory-mapped timer peripheral; responder on the core's data-memory port (daddr/ddata_w/MemRead/MemWrite -> ddata_r).
// - Sits beside RAM in top; decodes its own address window; read data timed like RAM (registered, 1 cycle), so top muxes on hit_q.
// - Prescaled up-counter, compare match, sticky status flag, interrupt request to the core.
// PARAMETERS
// - BASE_ADDR  32'h0000_1000  window base; window = BASE_ADDR[31:8], 256 bytes
// - CNT_W      32             COUNT/COMPARE width (<=32); reads zero-extended
// - PRE_W      16             PRESCALE width
// PORTS
// - CLK       in   1   system clock, single clock domain
// - RESET_N   in   1   asynchronous, active-low reset
// - daddr     in   32  byte address from core
// - ddata_w   in   32  write data
// - MemRead   in   1   read strobe
// - MemWrite  in   1   write strobe
// - ddata_r   out  32  read data, registered
// - hit_q     out  1   registered "ddata_r is mine"; top selects ddata_r vs RAM
// - irq       out  1   registered interrupt request, level
// BEHAVIOUR
// - Hit: daddr[31:8]==BASE_ADDR[31:8]; word offset = daddr[7:2]; daddr[1:0] ignored (word access only).
// - Map: 0x00 CTRL{[0]EN,[1]AUTO_RLD,[2]IRQ_EN}; 0x04 PRESCALE; 0x08 COUNT; 0x0C COMPARE; 0x10 STATUS{[0]MATCH, W1C}.
// - Unmapped offsets in window: read 0, writes ignored. Reserved bits read 0.
// - Reset: all registers 0, ddata_r=0, hit_q=0, irq=0, FSM IDLE, prescaler counter 0.
// - Read: MemRead&hit at edge N -> ddata_r/hit_q valid after edge N+1 (1-cycle latency); no hit -> ddata_r=0, hit_q=0.
// - Write: MemWrite&hit commits at the edge. MemRead&MemWrite same cycle: write commits, read returns pre-write value.
// - Prescaler: pcnt counts 0..PRESCALE, tick when pcnt==PRESCALE then pcnt<=0; PRESCALE=0 -> tick every cycle in RUN.
// - Any write to PRESCALE or CTRL.EN 1->0 clears pcnt.
// - FSM IDLE: EN=0, COUNT held; write EN=1 -> RUN next cycle.
// - FSM RUN: on tick COUNT<=COUNT+1 (wraps at 2^CNT_W-1 -> 0, no flag).
//   On tick with COUNT==COMPARE: MATCH<=1; AUTO_RLD=1 -> COUNT<=0, stay RUN; AUTO_RLD=0 -> EN<=0, COUNT held, -> IDLE.
//   Write EN=0 -> IDLE.
// - Priorities: bus write to COUNT beats tick increment/reload same cycle;
//   new match beats W1C clear same cycle (MATCH stays 1);
//   bus write EN=1 same cycle as one-shot auto-clear -> EN=1, stays RUN.
// - irq <= MATCH & IRQ_EN, one cycle after MATCH/IRQ_EN change; drops one cycle after W1C.
// - RESET_N low mid-count: everything returns to reset values immediately (async), pending read data discarded.
// CONFIGURATION
// - TIMER_CYCLE_CNT_EN defined: free-running 64-bit cycle counter, +1 every CLK from reset;
//   0x14 CYC_LO, 0x18 CYC_HI (read-only, writes ignored); reading CYC_LO latches CYC_HI into a shadow
//   so the following CYC_HI read is coherent.
// - Not defined: no counter logic; 0x14/0x18 read 0 like any unmapped offset.
// STRUCTURE
// - Package timer_pkg: register offset localparams, CTRL/STATUS bit-position localparams,
//   typedef enum logic {T_IDLE, T_RUN} timer_state_t.
// - Sub-module timer_prescaler: pcnt register, PRESCALE compare, clear and enable inputs, tick output.
// - Top level: address decode, register file, FSM, read mux/register, irq register.
// TESTING
// - Reset then read 0x00..0x10 -> ddata_r=0 one cycle after each MemRead, hit_q=1; address 0x2000 -> hit_q=0.
// - PRESCALE=0, COMPARE=5, CTRL=0x1 -> COUNT 1..5, MATCH=1, EN auto-cleared, COUNT stays 5, FSM IDLE.
// - PRESCALE=3, COMPARE=2, CTRL=0x7 -> tick every 4 cycles, irq high at 3rd tick + 1 cycle, COUNT reloads to 0, counting continues.
// - STATUS write 0x1 -> irq low next cycle; W1C in same cycle as a new match -> MATCH stays 1.
// - Write COUNT=0xFFFF_FFFF while running at PRESCALE=0 -> write wins, then wraps to 0 on next tick; MemRead+MemWrite COMPARE same cycle -> old value read.
// - TIMER_CYCLE_CNT_EN: read CYC_LO then CYC_HI across a low-word carry -> 64-bit value coherent; undefined build -> both read 0.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped timer: register word offsets, bit positions, FSM states.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package timer_pkg;

    // Word offsets within the 256-byte window (daddr[7:2])
    localparam logic [5:0] OFF_CTRL     = 6'h00;
    localparam logic [5:0] OFF_PRESCALE = 6'h01;
    localparam logic [5:0] OFF_COUNT    = 6'h02;
    localparam logic [5:0] OFF_COMPARE  = 6'h03;
    localparam logic [5:0] OFF_STATUS   = 6'h04;
    localparam logic [5:0] OFF_CYC_LO   = 6'h05;
    localparam logic [5:0] OFF_CYC_HI   = 6'h06;

    // CTRL / STATUS bit positions
    localparam int CTRL_EN_BIT       = 0;
    localparam int CTRL_AUTO_RLD_BIT = 1;
    localparam int CTRL_IRQ_EN_BIT   = 2;
    localparam int STATUS_MATCH_BIT  = 0;

    typedef enum logic {T_IDLE, T_RUN} timer_state_t;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler: pcnt counts 0..PRESCALE while enabled and pulses a tick on the terminal value.
// Latency: tick is combinational from the current pcnt; pcnt updates at the clock edge.
// Backpressure: none; clear has priority over counting, pcnt holds while disabled.
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int PRE_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [PRE_W-1:0] i_prescale,
    output logic             o_tick
);

    logic [PRE_W-1:0] r_pcnt;
    logic             w_wrap;

    assign w_wrap = (r_pcnt == i_prescale);
    assign o_tick = i_en & w_wrap;

    // Count up to PRESCALE then restart; clear wins over counting
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pcnt <= '0;
        end else if (i_clr) begin
            r_pcnt <= '0;
        end else if (i_en) begin
            r_pcnt <= w_wrap ? '0 : r_pcnt + PRE_W'(1);
        end
    end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped prescaled timer with compare match, sticky W1C status and level irq.
// Latency: reads return registered data one cycle after MemRead; writes commit at the edge.
// Backpressure: none; always ready. Optional macro TIMER_CYCLE_CNT_EN adds a 64-bit cycle counter.
module mmio_timer
    import timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int          CNT_W     = 32,
    parameter int          PRE_W     = 16
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [31:0] daddr,
    input  logic [31:0] ddata_w,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] ddata_r,
    output logic        hit_q,
    output logic        irq
);

    // Address decode
    logic       w_hit;
    logic [5:0] w_off;
    logic       w_rd;
    logic       w_wr;
    logic       w_wr_ctrl;
    logic       w_wr_pre;
    logic       w_wr_count;
    logic       w_wr_compare;
    logic       w_wr_status;

    assign w_hit        = (daddr[31:8] == BASE_ADDR[31:8]);
    assign w_off        = daddr[7:2];
    assign w_rd         = MemRead & w_hit;
    assign w_wr         = MemWrite & w_hit;
    assign w_wr_ctrl    = w_wr && (w_off == OFF_CTRL);
    assign w_wr_pre     = w_wr && (w_off == OFF_PRESCALE);
    assign w_wr_count   = w_wr && (w_off == OFF_COUNT);
    assign w_wr_compare = w_wr && (w_off == OFF_COMPARE);
    assign w_wr_status  = w_wr && (w_off == OFF_STATUS);

    // Byte lanes below word granularity are not decoded
    logic w_unused_bits;
    assign w_unused_bits = &{daddr[1:0], ddata_w};

    // Register file
    timer_state_t     r_state;
    timer_state_t     w_state_nxt;
    logic             r_en;
    logic             r_auto;
    logic             r_irq_en;
    logic [PRE_W-1:0] r_prescale;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_compare;
    logic             r_match;

    logic             w_en_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_match_set;
    logic             w_tick;
    logic             w_pcnt_clr;
    logic [31:0]      w_rdata;

    // Prescaler stops clearing only on a real EN 1->0 transition or a PRESCALE write
    assign w_pcnt_clr = w_wr_pre | (r_en & ~w_en_nxt);

    timer_prescaler #(
        .PRE_W (PRE_W)
    ) u_prescaler (
        .i_clk      (CLK),
        .i_rst_n    (RESET_N),
        .i_en       (r_state == T_RUN),
        .i_clr      (w_pcnt_clr),
        .i_prescale (r_prescale),
        .o_tick     (w_tick)
    );

    // FSM state register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= T_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, EN and COUNT; bus writes are applied last so they win over tick effects
    always_comb begin
        w_state_nxt = r_state;
        w_en_nxt    = r_en;
        w_cnt_nxt   = r_count;
        w_match_set = 1'b0;
        case (r_state)
            T_IDLE: begin
                if (w_wr_ctrl) begin
                    w_en_nxt = ddata_w[CTRL_EN_BIT];
                    if (ddata_w[CTRL_EN_BIT]) begin
                        w_state_nxt = T_RUN;
                    end
                end
            end
            T_RUN: begin
                if (w_tick) begin
                    if (r_count == r_compare) begin
                        w_match_set = 1'b1;
                        if (r_auto) begin
                            w_cnt_nxt = '0;
                        end else begin
                            w_en_nxt    = 1'b0;
                            w_state_nxt = T_IDLE;
                        end
                    end else begin
                        w_cnt_nxt = r_count + CNT_W'(1);
                    end
                end
                if (w_wr_ctrl) begin
                    w_en_nxt    = ddata_w[CTRL_EN_BIT];
                    w_state_nxt = ddata_w[CTRL_EN_BIT] ? T_RUN : T_IDLE;
                end
            end
            default: begin
                w_state_nxt = T_IDLE;
                w_en_nxt    = 1'b0;
            end
        endcase
        if (w_wr_count) begin
            w_cnt_nxt = ddata_w[CNT_W-1:0];
        end
    end

    // Register updates; a new match overrides a same-cycle W1C clear
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_en       <= 1'b0;
            r_auto     <= 1'b0;
            r_irq_en   <= 1'b0;
            r_prescale <= '0;
            r_count    <= '0;
            r_compare  <= '0;
            r_match    <= 1'b0;
        end else begin
            r_en    <= w_en_nxt;
            r_count <= w_cnt_nxt;
            if (w_wr_ctrl) begin
                r_auto   <= ddata_w[CTRL_AUTO_RLD_BIT];
                r_irq_en <= ddata_w[CTRL_IRQ_EN_BIT];
            end
            if (w_wr_pre) begin
                r_prescale <= ddata_w[PRE_W-1:0];
            end
            if (w_wr_compare) begin
                r_compare <= ddata_w[CNT_W-1:0];
            end
            if (w_match_set) begin
                r_match <= 1'b1;
            end else if (w_wr_status && ddata_w[STATUS_MATCH_BIT]) begin
                r_match <= 1'b0;
            end
        end
    end

`ifdef TIMER_CYCLE_CNT_EN
    logic [63:0] r_cyc;
    logic [31:0] r_cyc_hi_shadow;

    // Free-running cycle counter; a CYC_LO read snapshots the high word for a coherent CYC_HI read
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cyc           <= '0;
            r_cyc_hi_shadow <= '0;
        end else begin
            r_cyc <= r_cyc + 64'd1;
            if (w_rd && (w_off == OFF_CYC_LO)) begin
                r_cyc_hi_shadow <= r_cyc[63:32];
            end
        end
    end
`endif

    // Read mux over pre-write register values; reserved bits and unmapped offsets read 0
    always_comb begin
        w_rdata = '0;
        case (w_off)
            OFF_CTRL: begin
                w_rdata[CTRL_EN_BIT]       = r_en;
                w_rdata[CTRL_AUTO_RLD_BIT] = r_auto;
                w_rdata[CTRL_IRQ_EN_BIT]   = r_irq_en;
            end
            OFF_PRESCALE: w_rdata[PRE_W-1:0] = r_prescale;
            OFF_COUNT:    w_rdata[CNT_W-1:0] = r_count;
            OFF_COMPARE:  w_rdata[CNT_W-1:0] = r_compare;
            OFF_STATUS:   w_rdata[STATUS_MATCH_BIT] = r_match;
`ifdef TIMER_CYCLE_CNT_EN
            OFF_CYC_LO:   w_rdata = r_cyc[31:0];
            OFF_CYC_HI:   w_rdata = r_cyc_hi_shadow;
`endif
            default:      w_rdata = '0;
        endcase
    end

    // Registered read response and interrupt level
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ddata_r <= '0;
            hit_q   <= 1'b0;
            irq     <= 1'b0;
        end else begin
            ddata_r <= w_rd ? w_rdata : 32'd0;
            hit_q   <= w_rd;
            irq     <= r_match & r_irq_en;
        end
    end

endmodule
